ayatsuki_irq_ctrl: RTL and testbench



---
 rtl/ayatsuki_irq_ctrl_pkg.sv | 30 +++
 rtl/ayatsuki_irq_src.sv | 40 ++++
 rtl/ayatsuki_irq_ctrl.sv | 109 ++++++++++
 tb/tb_ayatsuki_irq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ayatsuki_irq_ctrl_pkg.sv
// Shared constants for the memory-mapped interrupt controller: bus widths, window size,
// register offsets and the write-request payload.
package ayatsuki_irq_ctrl_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WIN_BYTES = 32;
  localparam int unsigned OFF_W     = $clog2(WIN_BYTES);

  localparam logic [OFF_W-1:0] IRQ_OFF_PENDING = OFF_W'(5'h00);
  localparam logic [OFF_W-1:0] IRQ_OFF_ENABLE  = OFF_W'(5'h04);
  localparam logic [OFF_W-1:0] IRQ_OFF_TRIGGER = OFF_W'(5'h08);
  localparam logic [OFF_W-1:0] IRQ_OFF_STATUS  = OFF_W'(5'h0C);
  localparam logic [OFF_W-1:0] IRQ_OFF_SWSET   = OFF_W'(5'h10);

  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  typedef struct packed {
    logic              w_en;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] data;
  } irq_wr_t;

  // True when addr falls inside the 32-byte window starting at base.
  function automatic logic win_hit(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] base);
    return addr[ADDR_W-1:OFF_W] == base[ADDR_W-1:OFF_W];
  endfunction

endpackage

// File: rtl/ayatsuki_irq_src.sv
// Per-source front end: optional two-flop synchronizer (IRQ_SYNC_EN), previous-value
// flop and rising-edge detect.
module ayatsuki_irq_src (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  output logic src_c_o,
  output logic rise_c_o
);

`ifdef IRQ_SYNC_EN
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= src_i;
      sync_q <= meta_q;
    end
  end

  assign src_c_o = sync_q;
`else
  assign src_c_o = src_i;
`endif

  logic prev_q;

  // Resetting to 0 turns a source held high through reset into an edge after release.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= src_c_o;
  end

  assign rise_c_o = src_c_o & ~prev_q;

endmodule

// File: rtl/ayatsuki_irq_ctrl.sv
// Memory-mapped interrupt controller on the core data port: edge/level latching,
// masking and one-cycle registered reads. Build option: IRQ_SYNC_EN.
module ayatsuki_irq_ctrl
  import ayatsuki_irq_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_NUM   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] irq_src_i,
  input  logic               mem_enable_i,
  input  logic               mem_w_enable_i,
  input  logic               mem_r_enable_i,
  input  logic [31:0]        mem_w_addr_i,
  input  logic [31:0]        mem_r_addr_i,
  input  logic [31:0]        mem_data_i,
  output logic [31:0]        mem_data_o,
  output logic               mem_r_hit_o,
  output logic [IRQ_NUM-1:0] irq_req_o
);

  logic [IRQ_NUM-1:0] pend_q, pend_d;
  logic [IRQ_NUM-1:0] en_q, en_d;
  logic [IRQ_NUM-1:0] trig_q, trig_d;
  logic [IRQ_NUM-1:0] src_s;
  logic [IRQ_NUM-1:0] rise;
  logic [IRQ_NUM-1:0] w1c;
  logic [IRQ_NUM-1:0] sws;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rhit_q, rhit_d;
  logic [DATA_W-1:0]  rd_val;
  logic               rd_c;
  irq_wr_t            wr_c;
  logic               unused_data;

  for (genvar i = 0; i < int'(IRQ_NUM); i++) begin : g_src
    ayatsuki_irq_src u_src (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_i    (irq_src_i[i]),
      .src_c_o  (src_s[i]),
      .rise_c_o (rise[i])
    );
  end

  assign wr_c.w_en = mem_enable_i & mem_w_enable_i & win_hit(mem_w_addr_i, BASE_ADDR)
                     & (mem_w_addr_i[1:0] == 2'b00);
  assign wr_c.off  = mem_w_addr_i[OFF_W-1:0];
  assign wr_c.data = mem_data_i;
  assign unused_data = ^mem_data_i;

  // Any read inside the window claims the read mux; misaligned or unmapped offsets return 0.
  assign rd_c = mem_enable_i & mem_r_enable_i & win_hit(mem_r_addr_i, BASE_ADDR);

  always_comb begin
    rd_val = DATA_ZERO;
    if (mem_r_addr_i[1:0] == 2'b00) begin
      case (mem_r_addr_i[OFF_W-1:0])
        IRQ_OFF_PENDING: rd_val = DATA_W'(pend_q);
        IRQ_OFF_ENABLE:  rd_val = DATA_W'(en_q);
        IRQ_OFF_TRIGGER: rd_val = DATA_W'(trig_q);
        IRQ_OFF_STATUS:  rd_val = DATA_W'(pend_q & en_q);
        default:         rd_val = DATA_ZERO;
      endcase
    end
  end

  // Register writes; edge bits let a new set win over a same-cycle clear.
  always_comb begin
    en_d    = en_q;
    trig_d  = trig_q;
    w1c     = '0;
    sws     = '0;
    rdata_d = rd_c ? rd_val : DATA_ZERO;
    rhit_d  = rd_c;
    if (wr_c.w_en) begin
      case (wr_c.off)
        IRQ_OFF_PENDING: w1c    = wr_c.data[IRQ_NUM-1:0];
        IRQ_OFF_ENABLE:  en_d   = wr_c.data[IRQ_NUM-1:0];
        IRQ_OFF_TRIGGER: trig_d = wr_c.data[IRQ_NUM-1:0];
        IRQ_OFF_SWSET:   sws    = wr_c.data[IRQ_NUM-1:0];
        default: ;
      endcase
    end
    pend_d = (trig_q & ((pend_q & ~w1c) | rise | sws)) | (~trig_q & src_s);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q  <= '0;
      en_q    <= '0;
      trig_q  <= '0;
      rdata_q <= DATA_ZERO;
      rhit_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      en_q    <= en_d;
      trig_q  <= trig_d;
      rdata_q <= rdata_d;
      rhit_q  <= rhit_d;
    end
  end

  assign mem_data_o  = rdata_q;
  assign mem_r_hit_o = rhit_q;
  assign irq_req_o   = pend_q & en_q;

endmodule

// File: tb/tb_ayatsuki_irq_ctrl.sv
// Self-checking bench for ayatsuki_irq_ctrl: directed register/interrupt scenarios followed
// by random traffic, all compared against a cycle model built from the register rules.
module tb_ayatsuki_irq_ctrl;

  localparam int unsigned N    = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq_src;
  logic          men, mwe, mre;
  logic [31:0]   wa, ra, wd;
  logic [31:0]   rdata;
  logic          rhit;
  logic [N-1:0]  irq;

  always #5 clk = ~clk;

  ayatsuki_irq_ctrl #(.IRQ_NUM(N), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_src_i      (irq_src),
    .mem_enable_i   (men),
    .mem_w_enable_i (mwe),
    .mem_r_enable_i (mre),
    .mem_w_addr_i   (wa),
    .mem_r_addr_i   (ra),
    .mem_data_i     (wd),
    .mem_data_o     (rdata),
    .mem_r_hit_o    (rhit),
    .irq_req_o      (irq)
  );

  // Reference state
  logic [N-1:0] m_pend, m_en, m_trig, m_prev, m_s1, m_s2;
  logic [31:0]  m_data;
  logic         m_hit;
  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] reg_val(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 32'h0;
    case (a[4:0])
      5'h00:   return 32'(m_pend);
      5'h04:   return 32'(m_en);
      5'h08:   return 32'(m_trig);
      5'h0C:   return 32'(m_pend & m_en);
      default: return 32'h0;
    endcase
  endfunction

  // Applies one clock edge worth of register rules to the reference state.
  task automatic model_edge();
    logic [N-1:0] s, w1c, sws, dat;
    logic wok, rok;
    if (!rst_n) begin
      m_pend = '0; m_en = '0; m_trig = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
      m_data = '0; m_hit = 1'b0;
      return;
    end
    rok    = men && mre && (ra[31:5] == BASE[31:5]);
    m_data = rok ? reg_val(ra) : 32'h0;
    m_hit  = rok;
    wok = men && mwe && (wa[31:5] == BASE[31:5]) && (wa[1:0] == 2'b00);
    dat = wd[N-1:0];
    w1c = (wok && wa[4:0] == 5'h00) ? dat : '0;
    sws = (wok && wa[4:0] == 5'h10) ? dat : '0;
`ifdef IRQ_SYNC_EN
    s = m_s2; m_s2 = m_s1; m_s1 = irq_src;
`else
    s = irq_src;
`endif
    for (int i = 0; i < int'(N); i++) begin
      if (m_trig[i]) m_pend[i] = (m_pend[i] & ~w1c[i]) | (s[i] & ~m_prev[i]) | sws[i];
      else           m_pend[i] = s[i];
    end
    if (wok && wa[4:0] == 5'h04) m_en   = dat;
    if (wok && wa[4:0] == 5'h08) m_trig = dat;
    m_prev = s;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("irq_model",   32'(irq),  32'(m_pend & m_en));
    chk("rhit_model",  32'(rhit), 32'(m_hit));
    chk("rdata_model", rdata,     m_data);
  endtask

  task automatic idle();
    men = 1'b0; mwe = 1'b0; mre = 1'b0;
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    men = 1'b1; mwe = 1'b1; mre = 1'b0; wa = a; wd = d;
    step();
    men = 1'b0; mwe = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    men = 1'b1; mwe = 1'b0; mre = 1'b1; ra = a;
    step();
    men = 1'b0; mre = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_src = '0; men = 1'b0; mwe = 1'b0; mre = 1'b0;
    wa = '0; ra = '0; wd = '0;
    repeat (3) step();
    rst_n = 1'b1;
    idle();
    chk("rst_irq", 32'(irq), 32'h0);

    rd(32'h1000); chk("rst_pend", rdata, 32'h0); chk("rst_pend_hit", 32'(rhit), 32'h1);
    rd(32'h1004); chk("rst_en",   rdata, 32'h0); chk("rst_en_hit",   32'(rhit), 32'h1);
    rd(32'h1008); chk("rst_trig", rdata, 32'h0); chk("rst_trig_hit", 32'(rhit), 32'h1);

    // Edge interrupt on source 0
    wr(32'h1004, 32'h01); wr(32'h1008, 32'h01);
    irq_src = 8'h01; idle(); irq_src = 8'h00;
    repeat (LAT) idle();
    chk("edge_irq", 32'(irq), 32'h01);
    rd(32'h1000); chk("edge_pend_rd", rdata, 32'h01);
    wr(32'h1000, 32'h01); chk("edge_w1c", 32'(irq), 32'h00);

    // Set and clear landing on the same edge
    irq_src = 8'h01; idle(); irq_src = 8'h00;
    repeat (LAT + 1) idle();
    chk("coll_pre", 32'(irq), 32'h01);
    irq_src = 8'h01;
    repeat (LAT) idle();
    wr(32'h1000, 32'h01);
    chk("coll_set_wins", 32'(irq), 32'h01);
    irq_src = 8'h00;
    repeat (LAT + 1) idle();
    wr(32'h1000, 32'h01);
    chk("coll_clear", 32'(irq), 32'h00);

    // Level interrupt on source 2
    wr(32'h1008, 32'h00); wr(32'h1004, 32'h04);
    irq_src = 8'h04;
    repeat (LAT + 1) idle();
    chk("level_irq", 32'(irq), 32'h04);
    wr(32'h1000, 32'h04); chk("level_w1c_ignored", 32'(irq), 32'h04);
    irq_src = 8'h00; idle();
    repeat (LAT) idle();
    chk("level_drop", 32'(irq), 32'h00);

    // Masked edge on source 3, then unmask
    wr(32'h1004, 32'h00); wr(32'h1008, 32'h08);
    irq_src = 8'h08; idle(); irq_src = 8'h00;
    repeat (LAT + 1) idle();
    rd(32'h100C); chk("mask_status", rdata, 32'h00);
    rd(32'h1000); chk("mask_pend",   rdata, 32'h08);
    wr(32'h1004, 32'h08); chk("unmask_irq", 32'(irq), 32'h08);

    // Decode corner cases and SWSET
    wr(32'h1006, 32'hFF);
    rd(32'h1004); chk("misaligned_wr", rdata, 32'h08);
    rd(32'h1014); chk("unmapped_data", rdata, 32'h0); chk("unmapped_hit", 32'(rhit), 32'h1);
    rd(32'h0FFC); chk("outside_hit", 32'(rhit), 32'h0); chk("outside_data", rdata, 32'h0);
    wr(32'h1010, 32'h10);
    rd(32'h1000); chk("swset_level", rdata, 32'h08);
    wr(32'h1008, 32'h18); wr(32'h1010, 32'h10);
    rd(32'h1000); chk("swset_edge", rdata, 32'h18);
    rd(32'h1010); chk("swset_reads0", rdata, 32'h0);

    // Reset landing on a read
    men = 1'b1; mre = 1'b1; ra = 32'h1000; rst_n = 1'b0;
    step();
    chk("rst_mid_hit", 32'(rhit), 32'h0);
    chk("rst_mid_data", rdata, 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    rst_n = 1'b1; men = 1'b0; mre = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0: a = 32'h1000;  1: a = 32'h1004;  2: a = 32'h1008;
        3: a = 32'h100C;  4: a = 32'h1010;  5: a = 32'h1014;
        6: a = 32'h1002;  7: a = 32'h0FFC;  8: a = 32'h1020;
        default: a = 32'h1000;
      endcase
      irq_src = irq_src ^ N'($urandom & $urandom & $urandom);
      men = ($urandom_range(0, 3) != 0);
      mwe = $urandom_range(0, 1) == 1;
      mre = $urandom_range(0, 1) == 1;
      wa  = a;
      ra  = (($urandom_range(0, 1) == 1) ? a : 32'h1000 + 32'($urandom_range(0, 4) * 4));
      wd  = $urandom;
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    idle();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
